serial_adder_ctrl: RTL and testbench
====================================

// Module: serial_adder_ctrl
// PURPOSE
//  Sequencer that time-shares one Full_Adder cell to add two WIDTH-bit operands bit-serially, LSB first.
//  Owns operand shift registers, carry flip-flop, bit counter and a START/BUSY/DONE handshake.
//  Sits between a requester issuing add jobs and the single-bit adder datapath; trades latency for area.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 1
// PORTS
//  CLK    in   1      clock; all state changes on rising edge
//  RST    in   1      reset, asynchronous, active-high
//  START  in   1      request; sampled only in S_IDLE
//  A      in   WIDTH  operand A, captured on accepted START
//  B      in   WIDTH  operand B, captured on accepted START
//  CIN    in   1      carry-in, captured on accepted START
//  BUSY   out  1      high while in S_SHIFT
//  DONE   out  1      one-cycle pulse; SUM/COUT valid from this cycle on
//  SUM    out  WIDTH  registered result, held until the next job completes
//  COUT   out  1      registered carry-out of MSB, held like SUM
// BEHAVIOUR
//  - Reset (async, any time incl. mid-job): state=S_IDLE; shift regs, carry, counter, SUM, COUT, BUSY, DONE = 0
//  - FSM: S_IDLE -> S_SHIFT on START; S_SHIFT -> S_DONE after WIDTH bit-steps; S_DONE -> S_IDLE unconditionally
//  - Accept edge k (S_IDLE & START): areg<=A, breg<=B, creg<=CIN, cnt<=0, state<=S_SHIFT
//  - Each S_SHIFT edge: FA(areg[0],breg[0],creg) -> sum bit shifted into acc MSB, acc>>1;
//    areg>>1, breg>>1, creg<=FA carry, cnt<=cnt+1
//  - Edge k+WIDTH (cnt==WIDTH-1): SUM<=final acc incl. last bit, COUT<=last carry, state<=S_DONE
//  - DONE=1 for exactly the cycle after edge k+WIDTH; latency START-sample to DONE = WIDTH cycles;
//    throughput one job per WIDTH+2 cycles
//  - BUSY is a registered state decode (high only in S_SHIFT); DONE is high only in S_DONE
//  - START in S_SHIFT or S_DONE: ignored, not queued; A/B/CIN changes outside the accept edge have no effect
//  - SUM/COUT unchanged from reset/previous job until the S_SHIFT->S_DONE edge; never show partial results
//  - Arithmetic: {COUT,SUM} == A + B + CIN modulo 2^(WIDTH+1), unsigned
//  - WIDTH==1: single S_SHIFT cycle; cnt width = $clog2(WIDTH+1) so cnt never wraps
// CONFIGURATION
//  - Macro SERIAL_ADDER_OVF_EN defined: extra output OVF (1 bit, reset 0), registered with SUM:
//    OVF = carry into MSB XOR carry out of MSB (two's-complement overflow); held like SUM
//  - Macro not defined: no OVF port, no extra flop; all other behaviour identical
// STRUCTURE
//  - Package serial_adder_pkg: state_t enum {S_IDLE=2'd0, S_SHIFT=2'd1, S_DONE=2'd2};
//    localparam function cnt_w(width) = $clog2(width+1)
//  - One sub-module: Full_Adder (A, B, Cin, SUM, COUNT) instantiated once as the bit-step datapath;
//    serial_adder_ctrl contains FSM, shift regs, carry flop, counter and output regs only
// TESTING (WIDTH=8 unless stated; DONE checked exactly 8 cycles after accept edge)
//  1. A=0x00,B=0x00,CIN=0 -> SUM=0x00,COUT=0, BUSY high 8 cycles, DONE 1-cycle pulse
//  2. A=0xFF,B=0x01,CIN=0 -> SUM=0x00,COUT=1 (OVF=0 with SERIAL_ADDER_OVF_EN)
//  3. A=0x7F,B=0x00,CIN=1 -> SUM=0x80,COUT=0 (OVF=1 with macro); A=0xA5,B=0x5A,CIN=1 -> SUM=0x00,COUT=1
//  4. START held high through job, A/B changed while BUSY -> second job starts only after S_DONE->S_IDLE;
//     first result unaffected
//  5. RST pulsed at 4th S_SHIFT cycle -> all outputs 0 immediately, no DONE; next job A=0x03,B=0x04 -> 0x07
//  6. WIDTH=1: all 8 {A,B,CIN} combos -> {COUT,SUM} = 00,01,01,10,01,10,10,11 in order 000..111, DONE 1 cycle after accept

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    // Bit counter width; sized so it never wraps, even for WIDTH==1.
    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder: the one shared datapath cell of the serial adder.
module serial_adder_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic count
);

    // Sum and carry-out (count) of one bit position.
    assign sum   = a ^ b ^ cin;
    assign count = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder sequencer: adds two WIDTH-bit operands LSB first through
// one shared full adder, with a start/busy/done handshake.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement
// overflow output (ovf) that is updated together with sum/cout.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] areg;
    logic [WIDTH-1:0] breg;
    logic             creg;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             fa_sum;
    logic             fa_cout;

    // The one bit-step datapath cell, fed from the operand LSBs and the carry flop.
    serial_adder_full_adder u_fa (
        .a     (areg[0]),
        .b     (breg[0]),
        .cin   (creg),
        .sum   (fa_sum),
        .count (fa_cout)
    );

    // Accumulator after this step: new sum bit enters at the MSB.
    generate
        if (WIDTH == 1) begin : g_acc_1
            assign acc_nxt = fa_sum;
        end else begin : g_acc_n
            assign acc_nxt = {fa_sum, acc[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer FSM with operand shift registers, carry flop, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            areg  <= '0;
            breg  <= '0;
            creg  <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        areg  <= a;
                        breg  <= b;
                        creg  <= cin;
                        cnt   <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    areg <= areg >> 1;
                    breg <= breg >> 1;
                    creg <= fa_cout;
                    acc  <= acc_nxt;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_nxt;
                        cout  <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // creg holds the carry into the MSB on the last step.
                        ovf   <= creg ^ fa_cout;
`endif
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1 instances).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int nvec = 0;
    int nerr = 0;

    logic [7:0] last_sum;
    logic       last_cout;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_adder_ctrl #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Apply one job to the WIDTH=8 instance and check the whole handshake.
    task automatic run_job(input vec_t v);
        a     = v.a;
        b     = v.b;
        cin   = v.cin;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("busy_during_job", 32'(busy), 32'd1);
            check("done_during_job", 32'(done), 32'd0);
            check("sum_held", 32'(sum), 32'(last_sum));
            check("cout_held", 32'(cout), 32'(last_cout));
            // Operand changes while busy must not matter.
            a   = ~v.a;
            b   = v.b ^ 8'h3C;
            cin = ~v.cin;
            step();
        end
        check("done_pulse", 32'(done), 32'd1);
        check("busy_off", 32'(busy), 32'd0);
        check("sum", 32'(sum), 32'(v.sum));
        check("cout", 32'(cout), 32'(v.cout));
`ifdef SERIAL_ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(v.ovf));
`endif
        last_sum  = v.sum;
        last_cout = v.cout;
        step();
        check("done_one_cycle", 32'(done), 32'd0);
        check("sum_hold_after", 32'(sum), 32'(v.sum));
    endtask

    logic [1:0] exp1[8];

    initial begin
        vecs[0] = '{a: 8'h00, b: 8'h00, cin: 1'b0, sum: 8'h00, cout: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h7F, b: 8'h00, cin: 1'b1, sum: 8'h80, cout: 1'b0, ovf: 1'b1};
        vecs[3] = '{a: 8'hA5, b: 8'h5A, cin: 1'b1, sum: 8'h00, cout: 1'b1, ovf: 1'b0};
        vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, sum: 8'h00, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'h12, b: 8'h34, cin: 1'b0, sum: 8'h46, cout: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'hC3, b: 8'h6B, cin: 1'b1, sum: 8'h2F, cout: 1'b1, ovf: 1'b0};

        exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
        exp1[4] = 2'b01; exp1[5] = 2'b10; exp1[6] = 2'b10; exp1[7] = 2'b11;

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        last_sum = 8'h00; last_cout = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_busy1", 32'(busy1), 32'd0);
        rst = 1'b0;
        step();
        check("idle_busy", 32'(busy), 32'd0);

        // Table-driven jobs.
        for (int i = 0; i < 7; i++) begin
            run_job(vecs[i]);
        end

        // START held through a job with operands changing while busy.
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        step();
        a = 8'h7F; b = 8'h7F;
        for (int i = 0; i < 8; i++) begin
            check("held_busy", 32'(busy), 32'd1);
            step();
        end
        check("held_done", 32'(done), 32'd1);
        check("held_sum1", 32'(sum), 32'h30);
        check("held_cout1", 32'(cout), 32'd0);
        step();
        check("held_idle_busy", 32'(busy), 32'd0);
        check("held_idle_done", 32'(done), 32'd0);
        step();
        check("held_restart_busy", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("held_sum_kept", 32'(sum), 32'h30);
            step();
        end
        check("held_busy_last", 32'(busy), 32'd1);
        step();
        check("held_done2", 32'(done), 32'd1);
        check("held_sum2", 32'(sum), 32'hFE);
        check("held_cout2", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("held_ovf2", 32'(ovf), 32'd1);
`endif
        step();

        // Reset in the 4th shift cycle of a job.
        a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("pre_rst_busy", 32'(busy), 32'd1);
        check("pre_rst_sum", 32'(sum), 32'hFE);
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("midrst_ovf", 32'(ovf), 32'd0);
`endif
        #1;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_no_done", 32'(done), 32'd0);
            check("post_rst_no_busy", 32'(busy), 32'd0);
        end
        last_sum = 8'h00; last_cout = 1'b0;
        run_job('{a: 8'h03, b: 8'h04, cin: 1'b0, sum: 8'h07, cout: 1'b0, ovf: 1'b0});

        // WIDTH=1 instance: all operand combinations.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            a1 = v[2:2]; b1 = v[1:1]; cin1 = v[0]; start1 = 1'b1;
            step();
            start1 = 1'b0;
            check("w1_busy", 32'(busy1), 32'd1);
            check("w1_done_early", 32'(done1), 32'd0);
            step();
            check("w1_done", 32'(done1), 32'd1);
            check("w1_result", 32'({cout1, sum1}), 32'(exp1[i]));
`ifdef SERIAL_ADDER_OVF_EN
            check("w1_ovf", 32'(ovf1), 32'(v[0] ^ exp1[i][1]));
`endif
            step();
            check("w1_done_off", 32'(done1), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
